// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps the accumulator tuning word from a start word to a stop word, holding each word for a programmable dwell.
// Optional macro SWEEP_BIDIR_EN selects a triangular (up then down) sweep instead of the default up-only sweep.
module dds_sweep_ctrl #(
    parameter int FTW_W   = 13,
    parameter int DWELL_W = 16
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Loop_En,
    input  logic [FTW_W-1:0]   Start_FTW,
    input  logic [FTW_W-1:0]   Stop_FTW,
    input  logic [FTW_W-1:0]   Step_FTW,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [FTW_W-1:0]   FTW_Out,
    output logic               Phase_Clr,
    output logic               Busy,
    output logic               Done,
    output logic               Cfg_Err
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [FTW_W-1:0]   start_q, stop_q, step_q;
    logic [FTW_W-1:0]   start_nxt, stop_nxt, step_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt, cnt_q, cnt_nxt;
    logic               loop_q, loop_nxt;
    logic [FTW_W-1:0]   ftw_nxt;
    logic               phase_nxt, busy_nxt, done_nxt, err_nxt;
    logic               period_end;

    // Sums carry one extra bit so a step past an all-ones stop word never wraps.
    logic [FTW_W:0] up_sum;
    assign up_sum = {1'b0, FTW_Out} + {1'b0, step_q};

`ifdef SWEEP_BIDIR_EN
    logic           dir_down, dir_nxt;
    logic [FTW_W:0] lo_sum;
    assign lo_sum = {1'b0, start_q} + {1'b0, step_q};
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt  = state;
        start_nxt  = start_q;
        stop_nxt   = stop_q;
        step_nxt   = step_q;
        dwell_nxt  = dwell_q;
        loop_nxt   = loop_q;
        cnt_nxt    = cnt_q;
        ftw_nxt    = FTW_Out;
        phase_nxt  = 1'b0;
        busy_nxt   = Busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        period_end = 1'b0;
`ifdef SWEEP_BIDIR_EN
        dir_nxt    = dir_down;
`endif
        case (state)
            S_IDLE: begin
                if (Start && !Abort) begin
                    if (Step_FTW != '0 && Start_FTW <= Stop_FTW) begin
                        start_nxt = Start_FTW;
                        stop_nxt  = Stop_FTW;
                        step_nxt  = Step_FTW;
                        dwell_nxt = Dwell;
                        loop_nxt  = Loop_En;
                        cnt_nxt   = '0;
                        ftw_nxt   = Start_FTW;
                        phase_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = S_SWEEP;
`ifdef SWEEP_BIDIR_EN
                        dir_nxt   = 1'b0;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (Abort) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    ftw_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt_q == dwell_q) begin
                    cnt_nxt = '0;
`ifdef SWEEP_BIDIR_EN
                    if (!dir_down) begin
                        if (up_sum <= {1'b0, stop_q}) begin
                            ftw_nxt = up_sum[FTW_W-1:0];
                        end else if ({1'b0, FTW_Out} >= lo_sum) begin
                            dir_nxt = 1'b1;
                            ftw_nxt = FTW_Out - step_q;
                        end else begin
                            period_end = 1'b1;
                        end
                    end else if ({1'b0, FTW_Out} < lo_sum) begin
                        period_end = 1'b1;
                    end else begin
                        ftw_nxt = FTW_Out - step_q;
                    end
`else
                    if (up_sum <= {1'b0, stop_q}) begin
                        ftw_nxt = up_sum[FTW_W-1:0];
                    end else begin
                        period_end = 1'b1;
                    end
`endif
                    if (period_end) begin
                        if (loop_q) begin
                            ftw_nxt   = start_q;
                            phase_nxt = 1'b1;
`ifdef SWEEP_BIDIR_EN
                            dir_nxt   = 1'b0;
`endif
                        end else begin
                            state_nxt = S_DONE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            cnt_q     <= '0;
            FTW_Out   <= '0;
            Phase_Clr <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cfg_Err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= start_nxt;
            stop_q    <= stop_nxt;
            step_q    <= step_nxt;
            dwell_q   <= dwell_nxt;
            loop_q    <= loop_nxt;
            cnt_q     <= cnt_nxt;
            FTW_Out   <= ftw_nxt;
            Phase_Clr <= phase_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
            Cfg_Err   <= err_nxt;
        end
    end

`ifdef SWEEP_BIDIR_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) dir_down <= 1'b0;
        else       dir_down <= dir_nxt;
    end
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed test-plan cases plus randomized traffic against a word-list reference model.
module tb_dds_sweep_ctrl;

    localparam int FTW_W   = 13;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0, abort = 1'b0, loop_en = 1'b0;
    logic [FTW_W-1:0]   start_ftw = '0, stop_ftw = '0, step_ftw = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [FTW_W-1:0]   ftw_out;
    logic               phase_clr, busy, done, cfg_err;

    dds_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
        .CLK(clk), .RSTn(rstn), .Start(start), .Abort(abort), .Loop_En(loop_en),
        .Start_FTW(start_ftw), .Stop_FTW(stop_ftw), .Step_FTW(step_ftw), .Dwell(dwell),
        .FTW_Out(ftw_out), .Phase_Clr(phase_clr), .Busy(busy), .Done(done), .Cfg_Err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a sweep is the list of words it visits, each shown dwell+1 cycles.
    int words[$];
    int m_ftw = 0, m_pos = 0, m_age = 0, m_dwell = 0;
    bit m_phase = 0, m_busy = 0, m_done = 0, m_err = 0;
    bit m_run = 0, m_in_done = 0, m_loop = 0;

    task automatic build_words(input int s, input int e, input int st);
        int w;
        words.delete();
        w = s;
        while (w <= e) begin
            words.push_back(w);
            w += st;
        end
`ifdef SWEEP_BIDIR_EN
        w = words[$] - st;
        while (w >= s) begin
            words.push_back(w);
            w -= st;
        end
`endif
    endtask

    task automatic model_step();
        m_phase = 0; m_done = 0; m_err = 0;
        if (!rstn) begin
            m_ftw = 0; m_busy = 0; m_run = 0; m_in_done = 0;
            return;
        end
        if (m_in_done) begin
            m_in_done = 0;
            return;
        end
        if (m_run) begin
            if (abort) begin
                m_run = 0; m_busy = 0; m_ftw = 0;
                return;
            end
            if (m_age < m_dwell) begin
                m_age++;
                return;
            end
            m_age = 0;
            m_pos++;
            if (m_pos < words.size()) begin
                m_ftw = words[m_pos];
            end else if (m_loop) begin
                m_pos = 0; m_ftw = words[0]; m_phase = 1;
            end else begin
                m_run = 0; m_busy = 0; m_done = 1; m_in_done = 1;
            end
            return;
        end
        if (start && !abort) begin
            if (step_ftw != 0 && int'(start_ftw) <= int'(stop_ftw)) begin
                build_words(int'(start_ftw), int'(stop_ftw), int'(step_ftw));
                m_pos = 0; m_age = 0; m_dwell = int'(dwell); m_loop = loop_en;
                m_ftw = words[0]; m_phase = 1; m_busy = 1; m_run = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    int obs_busy, obs_done, obs_phase, obs_err;

    task automatic clear_obs();
        obs_busy = 0; obs_done = 0; obs_phase = 0; obs_err = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("ftw_out", 32'(ftw_out), 32'(m_ftw));
        check("phase_clr", 32'(phase_clr), 32'(m_phase));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        obs_busy  += int'(busy);
        obs_done  += int'(done);
        obs_phase += int'(phase_clr);
        obs_err   += int'(cfg_err);
    endtask

    task automatic set_cfg(input int s, input int e, input int st, input int dw, input bit lp);
        start_ftw = FTW_W'(s); stop_ftw = FTW_W'(e); step_ftw = FTW_W'(st);
        dwell = DWELL_W'(dw); loop_en = lp;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // One-shot up sweep 1..4, dwell 2.
        set_cfg(1, 4, 1, 2, 0);
        clear_obs();
        pulse_start();
        repeat (19) tick();
`ifdef SWEEP_BIDIR_EN
        check("oneshot_busy_cycles", 32'(obs_busy), 32'd21);
        check("oneshot_final_ftw", 32'(ftw_out), 32'd1);
`else
        check("oneshot_busy_cycles", 32'(obs_busy), 32'd12);
        check("oneshot_final_ftw", 32'(ftw_out), 32'd4);
`endif
        check("oneshot_done_pulses", 32'(obs_done), 32'd1);
        check("oneshot_phase_pulses", 32'(obs_phase), 32'd1);
        repeat (4) tick();

        // Rejected configurations leave the output word alone.
        clear_obs();
        set_cfg(1, 4, 0, 2, 0);
        pulse_start();
        tick();
        set_cfg(5, 3, 1, 2, 0);
        pulse_start();
        tick();
        check("cfg_err_pulses", 32'(obs_err), 32'd2);
        check("cfg_err_busy", 32'(obs_busy), 32'd0);
`ifdef SWEEP_BIDIR_EN
        check("cfg_err_ftw_held", 32'(ftw_out), 32'd1);
`else
        check("cfg_err_ftw_held", 32'(ftw_out), 32'd4);
`endif

        // Looped sweep, then abort.
        set_cfg(1, 4, 1, 2, 1);
        clear_obs();
        pulse_start();
        repeat (49) tick();
        check("loop_done_pulses", 32'(obs_done), 32'd0);
`ifdef SWEEP_BIDIR_EN
        check("loop_phase_pulses", 32'(obs_phase), 32'd3);
`else
        check("loop_phase_pulses", 32'(obs_phase), 32'd5);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_ftw", 32'(ftw_out), 32'd0);

        // Abort on the second cycle of word 3, which is also a dwell expiry.
        set_cfg(1, 4, 1, 1, 0);
        clear_obs();
        pulse_start();
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ftw", 32'(ftw_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("abort_no_done", 32'(obs_done), 32'd0);
        pulse_start();
        check("restart_ftw", 32'(ftw_out), 32'd1);
        check("restart_phase", 32'(phase_clr), 32'd1);
        repeat (12) tick();

        // Top of the word range: no wrap past all-ones.
        set_cfg(8190, 8191, 1, 0, 0);
        clear_obs();
        pulse_start();
        repeat (5) tick();
`ifdef SWEEP_BIDIR_EN
        check("top_busy_cycles", 32'(obs_busy), 32'd3);
        check("top_final_ftw", 32'(ftw_out), 32'd8190);
`else
        check("top_busy_cycles", 32'(obs_busy), 32'd2);
        check("top_final_ftw", 32'(ftw_out), 32'd8191);
`endif
        check("top_done_pulses", 32'(obs_done), 32'd1);

        // Reset in the middle of a sweep.
        set_cfg(2, 20, 3, 1, 0);
        pulse_start();
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ftw", 32'(ftw_out), 32'd0);
        rstn = 1'b1;
        tick();

        // Randomized traffic; config inputs churn every cycle to exercise latching.
        for (int i = 0; i < 4000; i++) begin
            rstn  = ($urandom_range(0, 399) != 0);
            abort = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) begin
                start_ftw = FTW_W'(8191 - $urandom_range(0, 20));
                stop_ftw  = FTW_W'(8191 - $urandom_range(0, 10));
            end else begin
                start_ftw = FTW_W'($urandom_range(0, 30));
                stop_ftw  = FTW_W'($urandom_range(0, 40));
            end
            step_ftw = FTW_W'($urandom_range(0, 6));
            dwell    = DWELL_W'($urandom_range(0, 3));
            loop_en  = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rstn  = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
